// File: rtl/latency_data_memory_if.sv
// rtl/latency_data_memory_if.sv - request/response channel of the latency data memory
interface latency_data_memory_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  reqValid;
    logic                  reqReady;
    logic [ADDR_WIDTH-1:0] address;
    logic                  writeEnable;
    logic [WIDTH-1:0]      dataIn;
    logic                  respValid;
    logic [WIDTH-1:0]      dataOut;
    logic                  respError;

    modport master (
        output reqValid, address, writeEnable, dataIn,
        input  reqReady, respValid, dataOut, respError
    );

    modport slave (
        input  reqValid, address, writeEnable, dataIn,
        output reqReady, respValid, dataOut, respError
    );
endinterface

// File: rtl/latency_data_memory.sv
// rtl/latency_data_memory.sv - word RAM behind a valid/ready channel with fixed access latency
module latency_data_memory #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic clk,
    input  logic reset,
    latency_data_memory_if.slave bus
);
    localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]  LOAD_COUNT = 3'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 8) begin : gBadLatency
            $error("latency_data_memory: LATENCY must be in 1..8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    state_t                nextState;
    logic [2:0]            counter;
    logic [ADDR_WIDTH-1:0] latchedAddress;
    logic                  latchedWrite;
    logic [WIDTH-1:0]      latchedData;
    logic [WIDTH-1:0]      mem [DEPTH];

    logic                  accept;
    logic                  enterResp;
    logic                  fromBus;
    logic [ADDR_WIDTH-1:0] effAddress;
    logic                  effWrite;
    logic [WIDTH-1:0]      effData;
    logic                  misaligned;
    logic                  outOfRange;
    logic                  accessError;
    logic [IDX_W-1:0]      memIndex;

    assign accept    = (state == IDLE) && bus.reqValid;
    assign enterResp = (nextState == RESP) && (state != RESP);

    // With LATENCY=1 the access happens on the accept edge, so it must use the live request.
    assign fromBus     = (state == IDLE);
    assign effAddress  = fromBus ? bus.address     : latchedAddress;
    assign effWrite    = fromBus ? bus.writeEnable : latchedWrite;
    assign effData     = fromBus ? bus.dataIn      : latchedData;
    assign misaligned  = (effAddress[1:0] != 2'b00);
    assign outOfRange  = (effAddress >> 2) >= ADDR_WIDTH'(DEPTH);
    assign accessError = misaligned || outOfRange;
    assign memIndex    = effAddress[IDX_W+1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (bus.reqValid) begin
                    nextState = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            // Leave on the edge where the counter decrements to zero.
            WAIT: begin
                if (counter == 3'd1) begin
                    nextState = RESP;
                end
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.reqReady  = 1'b0;
        bus.respValid = 1'b0;
        case (state)
            IDLE:    bus.reqReady  = 1'b1;
            RESP:    bus.respValid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter        <= '0;
            latchedAddress <= '0;
            latchedWrite   <= 1'b0;
            latchedData    <= '0;
            bus.dataOut    <= '0;
            bus.respError  <= 1'b0;
        end else begin
            if (accept) begin
                counter        <= LOAD_COUNT;
                latchedAddress <= bus.address;
                latchedWrite   <= bus.writeEnable;
                latchedData    <= bus.dataIn;
            end else if (state == WAIT) begin
                counter <= counter - 3'd1;
            end
            if (enterResp) begin
                if (accessError) begin
                    bus.dataOut   <= '0;
                    bus.respError <= 1'b1;
                end else begin
                    bus.dataOut   <= effWrite ? effData : mem[memIndex];
                    bus.respError <= 1'b0;
                end
            end
        end
    end

    // Array is never reset; the reset guard keeps an abandoned store from committing.
    always_ff @(posedge clk) begin
        if (!reset && enterResp && effWrite && !accessError) begin
            mem[memIndex] <= effData;
        end
    end
endmodule

// File: tb/tb_latency_data_memory.sv
// tb/tb_latency_data_memory.sv - scoreboard bench for latency_data_memory at LATENCY 2, 1 and 8
module tb_latency_data_memory;
    localparam int DEPTH = 1024;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int latOf(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    logic [2:0]  rv, we, rdy, rsp, rerr;
    logic [31:0] ad [3];
    logic [31:0] di [3];
    logic [31:0] dout [3];

    latency_data_memory_if #(.WIDTH(32), .ADDR_WIDTH(32)) ifc0 ();
    latency_data_memory_if #(.WIDTH(32), .ADDR_WIDTH(32)) ifc1 ();
    latency_data_memory_if #(.WIDTH(32), .ADDR_WIDTH(32)) ifc2 ();

    latency_data_memory #(.WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(32), .LATENCY(2))
        u0 (.clk(clk), .reset(reset), .bus(ifc0.slave));
    latency_data_memory #(.WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(32), .LATENCY(1))
        u1 (.clk(clk), .reset(reset), .bus(ifc1.slave));
    latency_data_memory #(.WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(32), .LATENCY(8))
        u2 (.clk(clk), .reset(reset), .bus(ifc2.slave));

    assign ifc0.reqValid = rv[0]; assign ifc0.address = ad[0];
    assign ifc0.writeEnable = we[0]; assign ifc0.dataIn = di[0];
    assign ifc1.reqValid = rv[1]; assign ifc1.address = ad[1];
    assign ifc1.writeEnable = we[1]; assign ifc1.dataIn = di[1];
    assign ifc2.reqValid = rv[2]; assign ifc2.address = ad[2];
    assign ifc2.writeEnable = we[2]; assign ifc2.dataIn = di[2];

    assign rdy[0] = ifc0.reqReady; assign rsp[0] = ifc0.respValid;
    assign rerr[0] = ifc0.respError; assign dout[0] = ifc0.dataOut;
    assign rdy[1] = ifc1.reqReady; assign rsp[1] = ifc1.respValid;
    assign rerr[1] = ifc1.respError; assign dout[1] = ifc1.dataOut;
    assign rdy[2] = ifc2.reqReady; assign rsp[2] = ifc2.respValid;
    assign rerr[2] = ifc2.respError; assign dout[2] = ifc2.dataOut;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sbq [3][$];
    logic [31:0] mdl [3][DEPTH];

    task automatic check(input int i, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s inst=%0d actual=%h required=%h time=%0t", name, i, act, req, $time);
        end
    endtask

    // Response monitor: every respValid pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (rsp[i]) begin
                if (sbq[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp inst=%0d actual=1 required=0 time=%0t", i, $time);
                end else begin
                    e = sbq[i].pop_front();
                    check(i, "resp_data", dout[i], e.data);
                    check(i, "resp_error", 32'(rerr[i]), 32'(e.err));
                    check(i, "resp_cycle", cyc, e.due);
                    check(i, "ready_in_resp", 32'(rdy[i]), 32'd0);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int i, input logic [31:0] a, input logic w, input logic [31:0] d,
                         input bit hold, input bit track, output int acc);
        exp_t e;
        int   n = 0;
        rv[i] = 1'b1; ad[i] = a; we[i] = w; di[i] = d;
        while (!rdy[i] && n < 60) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!rdy[i]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout inst=%0d actual=0 required=1", i);
            rv[i] = 1'b0;
            return;
        end
        if (track) begin
            e.err = (a % 4 != 0) || (a / 4 >= DEPTH);
            e.due = acc + latOf(i);
            if (e.err) begin
                e.data = 32'd0;
            end else if (w) begin
                mdl[i][a / 4] = d;
                e.data = d;
            end else begin
                e.data = mdl[i][a / 4];
            end
            sbq[i].push_back(e);
        end
        @(negedge clk);
        check(i, "ready_after_accept", 32'(rdy[i]), 32'd0);
        if (!hold) rv[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        int n = 0;
        while (sbq[i].size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sbq[i].size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout inst=%0d actual=%0d required=0", i, sbq[i].size());
            sbq[i].delete();
        end
        @(negedge clk);
    endtask

    task automatic op(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
        int acc;
        issue(i, a, w, d, 1'b0, 1'b1, acc);
        drain(i);
    endtask

    task automatic checkResetOutputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            check(i, {tag, "_ready"}, 32'(rdy[i]), 32'd1);
            check(i, {tag, "_respValid"}, 32'(rsp[i]), 32'd0);
            check(i, {tag, "_dataOut"}, dout[i], 32'd0);
            check(i, {tag, "_respError"}, 32'(rerr[i]), 32'd0);
        end
    endtask

    initial begin
        int          a1, a2, a3;
        logic [31:0] a;
        rv = '0;
        we = '0;
        for (int i = 0; i < 3; i++) begin
            ad[i] = '0;
            di[i] = '0;
        end
        #1 reset = 1'b1;
        #1 checkResetOutputs("reset_initial");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 32; w++) op(i, 32'(w * 4), 1'b1, $urandom);
        end

        for (int i = 0; i < 3; i++) begin
            op(i, 32'd28, 1'b1, 32'hDEADBEEF);
            op(i, 32'd28, 1'b0, 32'h0);
            op(i, 32'd30, 1'b1, 32'd5);
            op(i, 32'd28, 1'b0, 32'h0);
            op(i, 32'd4096, 1'b0, 32'h0);
            op(i, 32'd4092, 1'b0, 32'h0);
            op(i, 32'd28, 1'b0, 32'h0);
        end

        // Asynchronous reset while the clock is high and all outputs hold non-zero data.
        @(posedge clk);
        #2 reset = 1'b1;
        #1 checkResetOutputs("reset_async");
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            issue(i, 32'd0, 1'b0, 32'h0, 1'b1, 1'b1, a1);
            issue(i, 32'd4, 1'b0, 32'h0, 1'b1, 1'b1, a2);
            issue(i, 32'd8, 1'b0, 32'h0, 1'b0, 1'b1, a3);
            check(i, "b2b_spacing_1", 32'(a2 - a1), 32'(latOf(i) + 1));
            check(i, "b2b_spacing_2", 32'(a3 - a2), 32'(latOf(i) + 1));
            drain(i);
        end

        // Store abandoned by a reset one cycle after acceptance must never land.
        issue(0, 32'd8, 1'b1, 32'd7, 1'b0, 1'b0, a1);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (4) @(negedge clk);
        op(0, 32'd8, 1'b0, 32'h0);

        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 40; k++) begin
                case ($urandom_range(0, 9))
                    7:       a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
                    8:       a = 32'd4096 + 32'($urandom_range(0, 1000) * 4);
                    9:       a = $urandom | 32'h8000_0000;
                    default: a = 32'($urandom_range(0, 31) * 4);
                endcase
                issue(i, a, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b1, a1);
            end
            rv[i] = 1'b0;
            drain(i);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
